// File: rtl/memory_unit.sv
// CPU bus target: decodes SDRAM / flash / I/O / unmapped and runs one start/done access at a time.
// bus_done 2 cycles after accept (I/O, unmapped) or 1 cycle after slave done; bus_start ignored outside IDLE.
module memory_unit #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_we,
  input  logic        bus_start,
  output logic [31:0] bus_q,
  output logic        bus_done,
  output logic        bus_err,
  output logic [25:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_start,
  input  logic [31:0] sdram_q,
  input  logic        sdram_done,
  output logic [22:0] flash_addr,
  output logic        flash_start,
  input  logic [31:0] flash_q,
  input  logic        flash_done,
  output logic [7:0]  io_addr,
  output logic [31:0] io_data,
  output logic        io_we,
  output logic        io_sel,
  input  logic [31:0] io_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {R_SDRAM, R_FLASH, R_IO, R_NONE} region_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_n;
  region_t     region, dec_region;
  logic [25:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_we;
  logic [9:0]  tmo_cnt;
  logic        timed_out;
  logic        accept;
  logic        slave_done;
  logic [31:0] slave_q;
  logic        tmo_hit;

  always_comb begin
    dec_region = R_NONE;
    if (!bus_addr[26])                 dec_region = R_SDRAM;
    else if (bus_addr[25:23] == 3'b000) dec_region = R_FLASH;
    else if (bus_addr[25:23] == 3'b001) dec_region = R_IO;
  end

  // I/O, unmapped and flash writes complete on the first ACCESS edge.
  always_comb begin
    slave_done = 1'b1;
    slave_q    = '0;
    case (region)
      R_SDRAM: begin
        slave_done = sdram_done;
        slave_q    = sdram_q;
      end
      R_FLASH: begin
        slave_done = lat_we | flash_done;
        slave_q    = flash_q;
      end
      R_IO:    slave_q = io_q;
      default: ;
    endcase
  end

  assign accept  = (state == IDLE) && bus_start;
  assign tmo_hit = (state == ACCESS) && !slave_done && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus_start) state_n = ACCESS;
      ACCESS:  if (slave_done || tmo_hit) state_n = DONE;
      DONE:    if (bus_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      region      <= R_NONE;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_we      <= 1'b0;
      tmo_cnt     <= '0;
      timed_out   <= 1'b0;
      bus_q       <= '0;
      bus_done    <= 1'b0;
      bus_err     <= 1'b0;
      sdram_start <= 1'b0;
      flash_start <= 1'b0;
      io_sel      <= 1'b0;
    end else begin
      sdram_start <= 1'b0;
      flash_start <= 1'b0;
      io_sel      <= 1'b0;
      // DONE spans two cycles: the settle cycle, then the bus_done cycle.
      bus_done    <= (state == DONE) && !bus_done;
      bus_err     <= (state == DONE) && !bus_done && timed_out;
      if (accept) begin
        region      <= dec_region;
        lat_addr    <= bus_addr[25:0];
        lat_data    <= bus_data;
        lat_we      <= bus_we;
        tmo_cnt     <= '0;
        timed_out   <= 1'b0;
        sdram_start <= (dec_region == R_SDRAM);
        flash_start <= (dec_region == R_FLASH) && !bus_we;
        io_sel      <= (dec_region == R_IO);
      end else if (state == ACCESS) begin
        if (slave_done) begin
          if (!lat_we) bus_q <= slave_q;
        end else if (tmo_hit) begin
          timed_out <= 1'b1;
          if (!lat_we) bus_q <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 10'd1;
        end
      end
    end
  end

  assign sdram_addr = lat_addr;
  assign sdram_data = lat_data;
  assign sdram_we   = lat_we && (region == R_SDRAM);
  assign flash_addr = lat_addr[22:0];
  assign io_addr    = lat_addr[7:0];
  assign io_data    = lat_data;
  assign io_we      = lat_we && (region == R_IO);

endmodule

// File: tb/tb_memory_unit.sv
// Directed, table-driven bench for memory_unit with a small SDRAM model and reactive slave responses.
module tb_memory_unit;

  localparam int TIMEOUT = 1023;
  localparam int K_NONE  = 0;
  localparam int K_SDRAM = 1;
  localparam int K_FLASH = 2;
  localparam int K_IO    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic        bus_start;
  logic [31:0] bus_q;
  logic        bus_done;
  logic        bus_err;
  logic [25:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_start;
  logic [31:0] sdram_q;
  logic        sdram_done;
  logic [22:0] flash_addr;
  logic        flash_start;
  logic [31:0] flash_q;
  logic        flash_done;
  logic [7:0]  io_addr;
  logic [31:0] io_data;
  logic        io_we;
  logic        io_sel;
  logic [31:0] io_q;

  always #5 clk = ~clk;

  memory_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done), .bus_err(bus_err),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_start(sdram_start), .sdram_q(sdram_q), .sdram_done(sdram_done),
    .flash_addr(flash_addr), .flash_start(flash_start), .flash_q(flash_q), .flash_done(flash_done),
    .io_addr(io_addr), .io_data(io_data), .io_we(io_we), .io_sel(io_sel), .io_q(io_q)
  );

  typedef struct {
    string       name;
    logic [26:0] addr;
    logic [31:0] data;
    logic        we;
    int          kind;
    int          lat;        // slave done driven in cycle lat after accept (0 = never)
    logic [31:0] rq;         // flash/io read data
    int          exp_strb;   // hex digits: sdram, flash, io strobe counts
    logic [31:0] exp_q;
    int          exp_done;   // cycle after accept in which bus_done is high
    logic        exp_err;
    logic [31:0] exp_saddr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [logic [25:0]];
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after bus_done.
  task automatic run_vec(input vec_t v);
    int c = 0;
    int done_c = -1;
    int s_cnt = 0, f_cnt = 0, i_cnt = 0;
    logic        err_d = 1'b0;
    logic [31:0] q_d = '0;
    logic [31:0] saddr = '0;
    logic        we_seen = 1'b0;
    bus_addr  = v.addr;
    bus_data  = v.data;
    bus_we    = v.we;
    bus_start = 1'b1;
    io_q      = (v.kind == K_IO)    ? v.rq : 32'h0BAD_0BAD;
    flash_q   = (v.kind == K_FLASH) ? v.rq : 32'h0BAD_F1A5;
    sdram_q   = 32'h0BAD_5D5D;
    while (done_c < 0 && c < TIMEOUT + 20) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        bus_start = 1'b0;
        we_seen   = sdram_we | io_we;
        case (v.kind)
          K_SDRAM: saddr = 32'(sdram_addr);
          K_FLASH: saddr = 32'(flash_addr);
          K_IO:    saddr = 32'(io_addr);
          default: saddr = '0;
        endcase
        if (v.kind == K_SDRAM && sdram_start && sdram_we) mem[sdram_addr] = sdram_data;
      end
      s_cnt += int'(sdram_start);
      f_cnt += int'(flash_start);
      i_cnt += int'(io_sel);
      if (bus_done) begin
        done_c = c;
        q_d    = bus_q;
        err_d  = bus_err;
      end
      // Wrong-slave done pulses in the strobe cycle must be ignored.
      sdram_done = (v.kind == K_SDRAM && c == v.lat) || (v.kind == K_FLASH && c == 1);
      flash_done = (v.kind == K_FLASH && c == v.lat) || (v.kind == K_SDRAM && c == 1);
      if (v.kind == K_SDRAM && c == v.lat)
        sdram_q = mem.exists(sdram_addr) ? mem[sdram_addr] : 32'hDEAD_BEEF;
    end
    sdram_done = 1'b0;
    flash_done = 1'b0;
    @(negedge clk);
    check({v.name, "_strobes"}, 32'(s_cnt * 256 + f_cnt * 16 + i_cnt), 32'(v.exp_strb));
    if (v.kind != K_NONE) check({v.name, "_slave_addr"}, saddr, v.exp_saddr);
    if (v.kind == K_SDRAM || v.kind == K_IO) check({v.name, "_slave_we"}, 32'(we_seen), 32'(v.we));
    check({v.name, "_done_cycle"}, 32'(done_c), 32'(v.exp_done));
    check({v.name, "_bus_q"}, q_d, v.exp_q);
    check({v.name, "_bus_err"}, 32'(err_d), 32'(v.exp_err));
    check({v.name, "_done_width"}, 32'({bus_done, bus_err}), 32'h0);
  endtask

  initial begin
    int cnt, sel_cnt, done_cnt, bad;
    vecs[0] = '{"io_rd",     27'h4800012, 32'h0,        1'b0, K_IO,    0, 32'hCAFE_0001, 'h001, 32'hCAFE_0001, 3, 1'b0, 32'h12};
    vecs[1] = '{"sdram_wr",  27'h0000ABC, 32'h1234_5678, 1'b1, K_SDRAM, 5, 32'h0,        'h100, 32'hCAFE_0001, 7, 1'b0, 32'hABC};
    vecs[2] = '{"sdram_rd",  27'h0000ABC, 32'h0,        1'b0, K_SDRAM, 2, 32'h0,        'h100, 32'h1234_5678, 4, 1'b0, 32'hABC};
    vecs[3] = '{"flash_rd",  27'h4000010, 32'h0,        1'b0, K_FLASH, 3, 32'hF1A5_0010, 'h010, 32'hF1A5_0010, 5, 1'b0, 32'h10};
    vecs[4] = '{"flash_wr",  27'h4000010, 32'h5555_5555, 1'b1, K_FLASH, 3, 32'h7777_7777, 'h000, 32'hF1A5_0010, 3, 1'b0, 32'h10};
    vecs[5] = '{"unmap_rd",  27'h5000000, 32'h0,        1'b0, K_NONE,  0, 32'h0,        'h000, 32'h0,        3, 1'b0, 32'h0};
    vecs[6] = '{"sdram_k1",  27'h0000ABC, 32'h0,        1'b0, K_SDRAM, 1, 32'h0,        'h100, 32'h1234_5678, 3, 1'b0, 32'hABC};
    vecs[7] = '{"io_wr",     27'h48000FF, 32'hA5A5_A5A5, 1'b1, K_IO,    0, 32'h0BAD_CAFE, 'h001, 32'h1234_5678, 3, 1'b0, 32'hFF};
    vecs[8] = '{"unmap_wr",  27'h7FFFFFF, 32'h6666_6666, 1'b1, K_NONE,  0, 32'h0,        'h000, 32'h1234_5678, 3, 1'b0, 32'h0};
    vecs[9] = '{"timeout",   27'h0000100, 32'h0,        1'b0, K_SDRAM, 0, 32'h0,        'h100, 32'h0,        TIMEOUT + 2, 1'b1, 32'h100};

    reset = 1'b0;
    bus_addr = '0; bus_data = '0; bus_we = 1'b0; bus_start = 1'b0;
    sdram_q = '0; sdram_done = 1'b0; flash_q = '0; flash_done = 1'b0; io_q = '0;
    repeat (3) @(negedge clk);
    check("rst_bus_q", bus_q, 32'h0);
    check("rst_pulses", 32'({bus_done, bus_err, sdram_start, flash_start, io_sel, sdram_we, io_we}), 32'h0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'h0);
    check("rst_sdram_data", sdram_data, 32'h0);
    check("rst_flash_addr", 32'(flash_addr), 32'h0);
    check("rst_io_addr_data", 32'(io_addr) | io_data, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({bus_done, bus_err, sdram_start, flash_start, io_sel}), 32'h0);
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // A done arriving after the timeout must not produce another completion.
    sdram_done = 1'b1;
    @(negedge clk);
    sdram_done = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(bus_done) + int'(bus_err);
    end
    check("late_done_quiet", 32'(cnt), 32'h0);
    check("late_done_bus_q", bus_q, 32'h0);

    // bus_start held high: one I/O access every 4 cycles.
    bus_addr = 27'h4800012; bus_we = 1'b0; io_q = 32'hCAFE_0002; bus_start = 1'b1;
    sel_cnt = 0; done_cnt = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (io_sel) begin
        sel_cnt++;
        if (c % 4 != 1) bad++;
      end
      if (bus_done) begin
        done_cnt++;
        if (c % 4 != 3) bad++;
      end
      if (c == 40) bus_start = 1'b0;
    end
    check("held_accepts", 32'(sel_cnt), 32'd10);
    check("held_dones", 32'(done_cnt), 32'd10);
    check("held_spacing", 32'(bad), 32'h0);
    check("held_bus_q", bus_q, 32'hCAFE_0002);
    repeat (2) @(negedge clk);

    // Reset in the middle of an SDRAM access.
    bus_addr = 27'h0000200; bus_we = 1'b0; bus_start = 1'b1;
    @(negedge clk);
    bus_start = 1'b0;
    check("mid_rst_strobe", 32'(sdram_start), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_drop", 32'({sdram_start, flash_start, io_sel, bus_done}), 32'h0);
    check("mid_rst_addr", 32'(sdram_addr), 32'h0);
    sdram_done = 1'b1;
    repeat (2) @(negedge clk);
    sdram_done = 1'b0;
    reset = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(bus_done) + int'(bus_err) + int'(sdram_start);
    end
    check("mid_rst_no_done", 32'(cnt), 32'h0);
    check("mid_rst_bus_q", bus_q, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
# memory_unit

Bus target for the B322 CPU. Accepts one word access at a time on the CPU bus (`bus_addr`, `bus_data`, `bus_we`, `bus_start`, `bus_q`, `bus_done`). Decodes the address into SDRAM, SPI flash, I/O or unmapped space, and runs a start/done handshake with the selected slave. Returns read data with a single-cycle `bus_done`. A timeout completes the access if a slave hangs.

## Interface
- TIMEOUT, 1023: cycles in ACCESS, counted from the cycle after accept, before a hung SDRAM/flash access is force-completed.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- bus_addr  in  27  CPU word address.
- bus_data  in  32  CPU write data.
- bus_we  in  1  1 = write.
- bus_start  in  1  request strobe, sampled only in IDLE.
- bus_q  out  32  read data, registered; holds its value until the next completion.
- bus_done  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse, coincident with `bus_done`, on timeout.
- sdram_addr  out  26;  sdram_data  out  32;  sdram_we  out  1;  sdram_start  out  1  one-cycle pulse;  sdram_q  in  32;  sdram_done  in  1.
- flash_addr  out  23;  flash_start  out  1  one-cycle pulse;  flash_q  in  32;  flash_done  in  1.
- io_addr  out  8;  io_data  out  32;  io_we  out  1;  io_sel  out  1  one-cycle strobe;  io_q  in  32, valid the cycle `io_sel` is high.

## Operation
- Address decode, on the latched `bus_addr`:
  - `addr[26]`=0: SDRAM, `sdram_addr`=`addr[25:0]`.
  - `addr[26:23]`=1000: flash, read-only, `flash_addr`=`addr[22:0]`.
  - `addr[26:23]`=1001: I/O, `io_addr`=`addr[7:0]`.
  - Anything else: unmapped.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `bus_start`=1 latches addr, data and we, then moves to ACCESS.
  - On the same edge, the selected strobe (`sdram_start`, `flash_start` or `io_sel`) is registered high for exactly one cycle.
  - Flash writes and unmapped accesses assert no strobe.
- ACCESS, SDRAM or flash: wait for the matching `*_done`. On the edge it is sampled high, capture `*_q` into `bus_q` (reads only) and move to DONE.
- ACCESS, I/O: on the first ACCESS edge, capture `io_q` (reads only) and move to DONE.
- ACCESS, unmapped or flash write: move to DONE on the first ACCESS edge. `bus_q` is set to 0 for reads; writes are dropped.
- Writes never modify `bus_q`.
- Timeout: a 10-bit counter clears on accept and increments each ACCESS cycle. When it reaches TIMEOUT with no `*_done`:
  - move to DONE with `bus_q`=0;
  - pulse `bus_err` together with `bus_done`.
- DONE: `bus_done`=1 for one cycle, then return to IDLE. `bus_start` is ignored in DONE and in ACCESS.
- Slave address, data and we outputs are driven from the latch and stay stable from the accept edge until IDLE is re-entered.
- `*_done` is ignored outside ACCESS, and is ignored from any slave other than the one selected. A late `*_done` after a timeout has no effect.

## Timing
- Reset values: state IDLE, `bus_q`=0, and every other output 0 (`bus_done`, `bus_err`, all strobes, all address/data/we outputs).
- Reset asserted mid-access aborts immediately: strobes drop and no `bus_done` is issued.
- Accept edge = E. The strobe is high during cycle E..E+1.
- I/O or unmapped: `bus_done` high during E+2..E+3. Fixed latency of 2 cycles.
- SDRAM or flash with `*_done` sampled at edge E+k (k ≥ 1): `bus_done` high during E+k+1..E+k+2.
  - `*_done` already high in the strobe cycle counts (k=1).
- Earliest next accept: the edge ending the `bus_done` cycle is still DONE, so it is ignored. The next accept is the first IDLE edge, one cycle after `bus_done` falls.
- Timeout: `bus_done` and `bus_err` high TIMEOUT+1 cycles after E.

## Test plan
- Reset then idle: all outputs 0, `bus_q`=0, no strobes while `bus_start`=0.
- I/O read of addr 0x4800012 with `io_q`=0xCAFE0001:
  - `io_sel` high one cycle, `io_addr`=0x12;
  - `bus_done` 2 cycles after accept, `bus_q`=0xCAFE0001.
- SDRAM write then read of 0x0000ABC:
  - write: `sdram_we`=1, `sdram_data`=0x12345678, model returns done after 5 cycles, `bus_done` 1 cycle later, `bus_q` unchanged;
  - read: returns 0x12345678.
- Flash read of 0x4000010 with `flash_done` after 3 cycles returns `flash_q`. Flash write to the same address asserts no `flash_start`, gives `bus_done` after 2 cycles and leaves `bus_q` unchanged.
- Timeout: SDRAM read with `sdram_done` held 0:
  - `bus_done` and `bus_err` together at TIMEOUT+1 cycles, `bus_q`=0;
  - a later `sdram_done` pulse produces nothing.
- Boundaries:
  - `bus_start` held high continuously: one accept per completion, never during ACCESS or DONE.
  - Reset pulled low mid-SDRAM access: strobes drop, no `bus_done`.
  - Unmapped 0x5000000 read: `bus_q`=0, no strobe.
